// File: rtl/array_collector_pkg.sv
// -----------------------------------------------------------------------------
// array_collector_types
//   Shared types and default configuration for the array collector.
//   - DATA_W_DEF / NUM_ELEM_DEF : default element width and array length
//   - st_e                      : handshake FSM state (read side / write side)
//   - arr_def_t                 : unpacked array of ints matching the default
//                                 configuration, for top-level and bench use
// -----------------------------------------------------------------------------
package array_collector_types;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_ELEM_DEF = 2;

  typedef enum logic {
    ST_READ  = 1'b0,
    ST_WRITE = 1'b1
  } st_e;

  typedef int arr_def_t [NUM_ELEM_DEF];

endpackage

// File: rtl/array_collector.sv
// -----------------------------------------------------------------------------
// array_collector
//   Gathers NUM_ELEM signed words from a sync/notify input port into an
//   internal array and offers the whole array on a sync/notify output port.
//   MODE=0 collects a full block per frame; MODE=1 keeps a sliding window and
//   emits after every new word once the window has filled.
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset
//   b_in         : signed input element
//   b_in_sync    : producer offers b_in this cycle
//   b_in_notify  : block is ready to accept b_in
//   b_out        : array, element i at [i*DATA_W +: DATA_W], element 0 oldest
//   b_out_sync   : consumer takes b_out this cycle
//   b_out_notify : b_out is valid and offered
//   frame_cnt    : completed output transfers, wraps modulo 2^CNT_W
//   win_full     : array holds NUM_ELEM valid elements
// -----------------------------------------------------------------------------
module array_collector
  import array_collector_types::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_ELEM = NUM_ELEM_DEF,
  parameter int MODE     = 0,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_W-1:0]     b_in,
  input  logic                         b_in_sync,
  output logic                         b_in_notify,
  output logic [NUM_ELEM*DATA_W-1:0]   b_out,
  input  logic                         b_out_sync,
  output logic                         b_out_notify,
  output logic [CNT_W-1:0]             frame_cnt,
  output logic                         win_full
);

  // A one-element window degenerates to block mode, so sliding behaviour is
  // only enabled when there is actually something to shift.
  localparam bit SLIDE = (MODE == 1) && (NUM_ELEM > 1);
  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  st_e                          state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         win_full_q, win_full_d;
  logic [CNT_W-1:0]             frame_cnt_q, frame_cnt_d;
  logic [NUM_ELEM*DATA_W-1:0]   b_out_q, b_out_d;
  logic signed [DATA_W-1:0]     arr_q [NUM_ELEM];
  logic signed [DATA_W-1:0]     arr_d [NUM_ELEM];
  logic [NUM_ELEM*DATA_W-1:0]   arr_flat_d;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_READ;
      idx_q       <= '0;
      win_full_q  <= 1'b0;
      frame_cnt_q <= '0;
      b_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      win_full_q  <= win_full_d;
      frame_cnt_q <= frame_cnt_d;
      b_out_q     <= b_out_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_elem
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          arr_q[gi] <= '0;
        end else begin
          arr_q[gi] <= arr_d[gi];
        end
      end

      // Flattened view of the next-cycle array, used to load b_out on the
      // same edge that completes a frame.
      assign arr_flat_d[gi*DATA_W +: DATA_W] = arr_d[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    win_full_d  = win_full_q;
    frame_cnt_d = frame_cnt_q;
    for (int j = 0; j < NUM_ELEM; j++) begin
      arr_d[j] = arr_q[j];
    end

    case (state_q)
      ST_READ: begin
        if (b_in_sync) begin
          if (SLIDE && win_full_q) begin
            // Window already full: drop the oldest, append the newest.
            for (int j = 0; j < NUM_ELEM - 1; j++) begin
              arr_d[j] = arr_q[j + 1];
            end
            arr_d[NUM_ELEM-1] = b_in;
            state_d           = ST_WRITE;
          end else begin
            for (int j = 0; j < NUM_ELEM; j++) begin
              if (idx_q == IDX_W'(j)) begin
                arr_d[j] = b_in;
              end
            end
            if (idx_q == LAST_IDX) begin
              // Sliding mode parks the index at the end; block mode rewinds.
              idx_d      = SLIDE ? LAST_IDX : '0;
              win_full_d = 1'b1;
              state_d    = ST_WRITE;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end

      ST_WRITE: begin
        if (b_out_sync) begin
          state_d     = ST_READ;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          if (!SLIDE) begin
            win_full_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_READ;
      end
    endcase
  end

  // b_out only changes on the edge that enters ST_WRITE, so it stays stable
  // for the whole time the frame is offered.
  always_comb begin
    b_out_d = b_out_q;
    if (state_q == ST_READ && state_d == ST_WRITE) begin
      b_out_d = arr_flat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign b_in_notify  = (state_q == ST_READ);
  assign b_out_notify = (state_q == ST_WRITE);
  assign b_out        = b_out_q;
  assign frame_cnt    = frame_cnt_q;
  assign win_full     = win_full_q;

endmodule
